// File: rtl/hue_wheel_sequencer.sv
// hue_wheel_sequencer: cycles the RGB LED around the HSV hue wheel with 8-bit PWM
// Ports:
//   clk, rst_n         12 MHz clock, synchronous active-low reset
//   run                1 = advance hue automatically, 0 = hold
//   step_req           one-cycle pulse, jumps one sector while holding
//   dir                0 = forward R->Y->G->C->B->M, 1 = reverse
//   brightness         global 8-bit scale
//   sector             current sector 0..5
//   sector_tick        one-cycle pulse on each sector change
//   RGB_R/RGB_G/RGB_B  active-low LED drives
module hue_wheel_sequencer #(
    parameter int RAMP_DIV = 7812,
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic                step_req,
    input  logic                dir,
    input  logic [7:0]          brightness,
    output logic [2:0]          sector,
    output logic                sector_tick,
    output logic                RGB_R,
    output logic                RGB_G,
    output logic                RGB_B
);
    localparam int PW = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(RAMP_DIV - 1);

    logic [PW-1:0]       presc;
    logic [7:0]          ramp;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] level_r, level_g, level_b;
    logic [PWM_BITS-1:0] lat_r, lat_g, lat_b;
    logic [7:0]          raw_r, raw_g, raw_b;
    logic [2:0]          sec_fwd, sec_rev;
    logic                ramp_evt;

    function automatic logic [7:0] scale(input logic [7:0] raw, input logic [7:0] b);
        logic [15:0] p;
        p = {8'd0, raw} * {8'd0, b};
        return p[15:8];
    endfunction

    always_comb begin
        ramp_evt = run && presc == PRESC_MAX;
        sec_fwd  = sector == 3'd5 ? 3'd0 : sector + 3'd1;
        sec_rev  = sector == 3'd0 ? 3'd5 : sector - 3'd1;
        raw_r    = 8'd0;
        raw_g    = 8'd0;
        raw_b    = 8'd0;
        case (sector)
            3'd0: begin raw_r = 8'hff;        raw_g = ramp;         end
            3'd1: begin raw_r = ~ramp;        raw_g = 8'hff;        end
            3'd2: begin raw_g = 8'hff;        raw_b = ramp;         end
            3'd3: begin raw_g = ~ramp;        raw_b = 8'hff;        end
            3'd4: begin raw_r = ramp;         raw_b = 8'hff;        end
            3'd5: begin raw_r = 8'hff;        raw_b = ~ramp;        end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc       <= '0;
            ramp        <= '0;
            sector      <= '0;
            sector_tick <= 1'b0;
            pwm_cnt     <= '0;
            level_r     <= '0;
            level_g     <= '0;
            level_b     <= '0;
            lat_r       <= '0;
            lat_g       <= '0;
            lat_b       <= '0;
            RGB_R       <= 1'b1;
            RGB_G       <= 1'b1;
            RGB_B       <= 1'b1;
        end else begin
            sector_tick <= 1'b0;
            // run is evaluated first, so a step request while running is dropped
            if (run) begin
                presc <= ramp_evt ? '0 : presc + 1'b1;
                if (ramp_evt && !dir) begin
                    ramp <= ramp + 8'd1;
                    if (ramp == 8'hff) begin
                        sector      <= sec_fwd;
                        sector_tick <= 1'b1;
                    end
                end else if (ramp_evt) begin
                    ramp <= ramp - 8'd1;
                    if (ramp == 8'h00) begin
                        sector      <= sec_rev;
                        sector_tick <= 1'b1;
                    end
                end
            end else if (step_req) begin
                sector      <= dir ? sec_rev : sec_fwd;
                ramp        <= '0;
                presc       <= '0;
                sector_tick <= 1'b1;
            end
            level_r <= scale(raw_r, brightness);
            level_g <= scale(raw_g, brightness);
            level_b <= scale(raw_b, brightness);
            pwm_cnt <= pwm_cnt + 1'b1;
            // levels only change at the PWM period boundary to avoid mid-period glitches
            if (pwm_cnt == '1) begin
                lat_r <= level_r;
                lat_g <= level_g;
                lat_b <= level_b;
            end
            RGB_R <= ~(pwm_cnt < lat_r);
            RGB_G <= ~(pwm_cnt < lat_g);
            RGB_B <= ~(pwm_cnt < lat_b);
        end
    end
endmodule
